// File: rtl/mmu_pkg.sv
// Shared MMU types: requester IDs, field widths and TLB attribute bundle.
// Imported by the TLB search arbiter and its picker.
package mmu_pkg;

  localparam int VPN2_W = 19;
  localparam int PFN_W  = 20;
  localparam int ASID_W = 8;

  typedef enum logic [1:0] {
    REQ_I    = 2'd0,
    REQ_D    = 2'd1,
    REQ_P    = 2'd2,
    REQ_NONE = 2'd3
  } req_id_e;

  typedef struct packed {
    logic [PFN_W-1:0] pfn;
    logic [2:0]       c;
    logic             d;
    logic             v;
  } tlb_attr_t;

endpackage

// File: rtl/tlb_search_arb_if.sv
// Requester handshakes, TLB search port and shared response bus
// of the TLB search arbiter.
interface tlb_search_arb_if
  import mmu_pkg::*;
#(
  parameter int TLBNUM = 16
);

  localparam int IW = $clog2(TLBNUM);

  logic              i_req;
  logic              d_req;
  logic              p_req;
  logic [VPN2_W-1:0] i_vpn2;
  logic [VPN2_W-1:0] d_vpn2;
  logic [VPN2_W-1:0] p_vpn2;
  logic              i_odd;
  logic              d_odd;
  logic              p_odd;
  logic              i_ready;
  logic              d_ready;
  logic              p_ready;
  logic [ASID_W-1:0] asid;
  logic              tlb_we;
  logic              flush;

  logic [VPN2_W-1:0] s_vpn2;
  logic              s_odd_page;
  logic [ASID_W-1:0] s_asid;
  logic              s_found;
  logic [IW-1:0]     s_index;
  logic [PFN_W-1:0]  s_pfn;
  logic [2:0]        s_c;
  logic              s_d;
  logic              s_v;

  logic              i_rvalid;
  logic              d_rvalid;
  logic              p_rvalid;
  logic              r_found;
  logic [IW-1:0]     r_index;
  logic [PFN_W-1:0]  r_pfn;
  logic [2:0]        r_c;
  logic              r_d;
  logic              r_v;

  modport slave (
    input  i_req, d_req, p_req,
    input  i_vpn2, d_vpn2, p_vpn2,
    input  i_odd, d_odd, p_odd,
    output i_ready, d_ready, p_ready,
    input  asid, tlb_we, flush,
    output s_vpn2, s_odd_page, s_asid,
    input  s_found, s_index, s_pfn, s_c, s_d, s_v,
    output i_rvalid, d_rvalid, p_rvalid,
    output r_found, r_index, r_pfn, r_c, r_d, r_v
  );

  modport master (
    output i_req, d_req, p_req,
    output i_vpn2, d_vpn2, p_vpn2,
    output i_odd, d_odd, p_odd,
    input  i_ready, d_ready, p_ready,
    output asid, tlb_we, flush,
    input  s_vpn2, s_odd_page, s_asid,
    output s_found, s_index, s_pfn, s_c, s_d, s_v,
    input  i_rvalid, d_rvalid, p_rvalid,
    input  r_found, r_index, r_pfn, r_c, r_d, r_v
  );

endinterface

// File: rtl/tlb_search_arb_pick.sv
// Fixed-priority picker p > d > i; promote_i lifts i above d only.
// Grant bits: [0]=i, [1]=d, [2]=p.
module tlb_arb_pick
  import mmu_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  logic       p_req,
  input  logic       promote_i,
  input  logic       block,
  output logic [2:0] gnt,
  output req_id_e    win
);

  // Terms are mutually exclusive so the grant is one-hot by construction.
  assign gnt[2] = !block && p_req;
  assign gnt[0] = !block && !p_req && i_req
                  && (promote_i || !d_req);
  assign gnt[1] = !block && !p_req && d_req
                  && !(promote_i && i_req);

  always_comb begin
    win = REQ_NONE;
    unique case (1'b1)
      gnt[0]:  win = REQ_I;
      gnt[1]:  win = REQ_D;
      gnt[2]:  win = REQ_P;
      default: win = REQ_NONE;
    endcase
  end

endmodule

// File: rtl/tlb_search_arb.sv
// Shares one TLB search port among inst MMU, data MMU and TLBP.
// Result is registered; owner tracks which requester gets rvalid.
module tlb_search_arb
  import mmu_pkg::*;
#(
  parameter int TLBNUM       = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic             clk,
  input  logic             reset,
  tlb_search_arb_if.slave  bus
);

  localparam int IW = $clog2(TLBNUM);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  logic [2:0]        gnt;
  req_id_e           win;
  req_id_e           owner;
  logic [SW-1:0]     starve_cnt;
  logic              promote;
  logic [VPN2_W-1:0] s_vpn2;
  logic              s_odd;
  logic              r_found;
  logic [IW-1:0]     r_index;
  tlb_attr_t         r_attr;
  logic              kill_grant;

  assign promote = (starve_cnt == LIM);

  // Reset blocks grants like a TLB write does.
  tlb_arb_pick u_pick (
    .i_req     (bus.i_req),
    .d_req     (bus.d_req),
    .p_req     (bus.p_req),
    .promote_i (promote),
    .block     (bus.tlb_we || reset),
    .gnt       (gnt),
    .win       (win)
  );

  assign bus.i_ready = gnt[0];
  assign bus.d_ready = gnt[1];
  assign bus.p_ready = gnt[2];

  always_comb begin
    s_vpn2 = bus.i_vpn2;
    s_odd  = bus.i_odd;
    unique case (1'b1)
      gnt[1]: begin
        s_vpn2 = bus.d_vpn2;
        s_odd  = bus.d_odd;
      end
      gnt[2]: begin
        s_vpn2 = bus.p_vpn2;
        s_odd  = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.s_vpn2     = s_vpn2;
  assign bus.s_odd_page = s_odd;
  assign bus.s_asid     = bus.asid;

  assign kill_grant = bus.flush
                      && (win == REQ_I || win == REQ_D);

  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= REQ_NONE;
      starve_cnt <= '0;
      r_found    <= 1'b0;
      r_index    <= '0;
      r_attr     <= '0;
    end else begin
      owner <= kill_grant ? REQ_NONE : win;
      if (win != REQ_NONE) begin
        r_found    <= bus.s_found;
        r_index    <= bus.s_index;
        r_attr.pfn <= bus.s_pfn;
        r_attr.c   <= bus.s_c;
        r_attr.d   <= bus.s_d;
        r_attr.v   <= bus.s_v;
      end
      if (!bus.i_req || gnt[0])
        starve_cnt <= '0;
      else if (starve_cnt != LIM)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Flush in the response cycle kills MMU responses, never TLBP.
  assign bus.i_rvalid = (owner == REQ_I) && !bus.flush && !reset;
  assign bus.d_rvalid = (owner == REQ_D) && !bus.flush && !reset;
  assign bus.p_rvalid = (owner == REQ_P) && !reset;

  assign bus.r_found = r_found;
  assign bus.r_index = r_index;
  assign bus.r_pfn   = r_attr.pfn;
  assign bus.r_c     = r_attr.c;
  assign bus.r_d     = r_attr.d;
  assign bus.r_v     = r_attr.v;

endmodule

// File: tb/tb_tlb_search_arb.sv
// Bench for tlb_search_arb: TLB model, response scoreboard
// and one task per scenario.
module tb_tlb_search_arb;
  import mmu_pkg::*;

  localparam int TLBNUM = 16;

  typedef struct {
    int          cyc;
    logic [1:0]  own;
    logic        found;
    logic [3:0]  idx;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } rsp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] gen = 4'd0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  rsp_t       sb[$];
  rsp_t       tlb_m;
  rsp_t       mon_e;
  logic [2:0] mon_rv;

  always #5 clk = ~clk;

  tlb_search_arb_if #(.TLBNUM(TLBNUM)) bus ();

  tlb_search_arb #(
    .TLBNUM       (TLBNUM),
    .STARVE_LIMIT (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic rsp_t mdl(input logic [1:0] own,
                               input logic [18:0] v,
                               input logic o,
                               input logic [3:0] g);
    rsp_t m;
    m.cyc   = 0;
    m.own   = own;
    m.found = ~v[1];
    m.idx   = v[3:0] ^ {3'b000, o};
    m.c     = v[6:4];
    m.d     = v[7];
    m.v     = o | v[8];
    if (v == 19'h00400 && o && g == 4'd0)
      m.pfn = 20'h1F00A;
    else
      m.pfn = {v[14:0], o, g} ^ 20'hA5A5A;
    return m;
  endfunction

  // TLB contents change with every committed write (gen).
  always_comb begin
    tlb_m = mdl(2'd0, bus.s_vpn2, bus.s_odd_page, gen);
    bus.s_found = tlb_m.found;
    bus.s_index = tlb_m.idx;
    bus.s_pfn   = tlb_m.pfn;
    bus.s_c     = tlb_m.c;
    bus.s_d     = tlb_m.d;
    bus.s_v     = tlb_m.v;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.tlb_we) gen <= gen + 4'd1;
  end

  always @(negedge clk) begin
    mon_rv = {bus.p_rvalid, bus.d_rvalid, bus.i_rvalid};
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_rsp cyc %0d got none want owner %0d",
               sb[0].cyc, sb[0].own);
      void'(sb.pop_front());
    end
    if (mon_rv != 3'b000) begin
      checks++;
      if (sb.size() == 0 || sb[0].cyc != cyc) begin
        errors++;
        $display("FAIL unexpected_rvalid cyc %0d got %b want 000",
                 cyc, mon_rv);
      end else begin
        mon_e = sb.pop_front();
        if (mon_rv !== (3'b001 << mon_e.own)
            || bus.r_found !== mon_e.found
            || bus.r_index !== mon_e.idx
            || bus.r_pfn !== mon_e.pfn
            || bus.r_c !== mon_e.c
            || bus.r_d !== mon_e.d
            || bus.r_v !== mon_e.v) begin
          errors++;
          $display("FAIL rsp cyc %0d got rv=%b f=%b i=%h pfn=%h c=%h d=%b v=%b want rv=%b f=%b i=%h pfn=%h c=%h d=%b v=%b",
                   cyc, mon_rv, bus.r_found, bus.r_index, bus.r_pfn,
                   bus.r_c, bus.r_d, bus.r_v, 3'b001 << mon_e.own,
                   mon_e.found, mon_e.idx, mon_e.pfn, mon_e.c,
                   mon_e.d, mon_e.v);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.i_req  = 1'b0;
    bus.d_req  = 1'b0;
    bus.p_req  = 1'b0;
    bus.tlb_we = 1'b0;
    bus.flush  = 1'b0;
  endtask

  task automatic expect_rsp(input logic [1:0] own,
                            input logic [18:0] v,
                            input logic o);
    rsp_t e;
    e = mdl(own, v, o, gen);
    e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic chk_rdy(input string name, input logic [2:0] want);
    logic [2:0] got;
    got = {bus.p_ready, bus.d_ready, bus.i_ready};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s ready got %b want %b", name, got, want);
    end
  endtask

  task automatic chk_rv(input string name, input logic [2:0] want);
    logic [2:0] got;
    got = {bus.p_rvalid, bus.d_rvalid, bus.i_rvalid};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s rvalid got %b want %b", name, got, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    bus.p_req = 1'b1;
    tick();
    #1;
    chk_rdy("reset_hold", 3'b000);
    chk_rv("reset_hold", 3'b000);
    checks++;
    if ({bus.r_found, bus.r_index, bus.r_pfn, bus.r_c,
         bus.r_d, bus.r_v} !== 30'd0) begin
      errors++;
      $display("FAIL reset_rbus got pfn=%h found=%b want 0",
               bus.r_pfn, bus.r_found);
    end
    tick();
    reset = 1'b0;
    clear_reqs();
    tick();
    #1;
    chk_rv("reset_after", 3'b000);
  endtask

  task automatic test_single();
    bus.i_req  = 1'b1;
    bus.i_vpn2 = 19'h00400;
    bus.i_odd  = 1'b1;
    #1;
    chk_rdy("single_grant", 3'b001);
    expect_rsp(REQ_I, 19'h00400, 1'b1);
    tick();
    bus.i_req = 1'b0;
    #1;
    chk_rv("single_rsp", 3'b001);
    checks++;
    if (bus.r_pfn !== 20'h1F00A || bus.r_v !== 1'b1) begin
      errors++;
      $display("FAIL single_pfn got %h v=%b want 1f00a v=1",
               bus.r_pfn, bus.r_v);
    end
    tick();
  endtask

  task automatic test_priority();
    bus.asid   = 8'h3C;
    bus.p_req  = 1'b1;
    bus.d_req  = 1'b1;
    bus.i_req  = 1'b1;
    bus.p_vpn2 = 19'h11111;
    bus.d_vpn2 = 19'h22222;
    bus.i_vpn2 = 19'h33333;
    bus.p_odd  = 1'b1;
    bus.d_odd  = 1'b1;
    bus.i_odd  = 1'b1;
    #1;
    chk_rdy("prio_p", 3'b100);
    checks++;
    if (bus.s_vpn2 !== 19'h11111 || bus.s_odd_page !== 1'b0
        || bus.s_asid !== 8'h3C) begin
      errors++;
      $display("FAIL prio_port got vpn=%h odd=%b asid=%h want 11111 0 3c",
               bus.s_vpn2, bus.s_odd_page, bus.s_asid);
    end
    expect_rsp(REQ_P, 19'h11111, 1'b0);
    tick();
    bus.p_req = 1'b0;
    #1;
    chk_rdy("prio_d", 3'b010);
    expect_rsp(REQ_D, 19'h22222, 1'b1);
    tick();
    bus.d_req = 1'b0;
    #1;
    chk_rdy("prio_i", 3'b001);
    expect_rsp(REQ_I, 19'h33333, 1'b1);
    tick();
    bus.i_req = 1'b0;
    tick();
  endtask

  task automatic test_starve();
    bus.d_req  = 1'b1;
    bus.d_vpn2 = 19'h0ABCD;
    bus.d_odd  = 1'b0;
    bus.i_req  = 1'b1;
    bus.i_vpn2 = 19'h01234;
    bus.i_odd  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (k % 4 == 3) begin
        chk_rdy("starve_i", 3'b001);
        expect_rsp(REQ_I, 19'h01234, 1'b1);
      end else begin
        chk_rdy("starve_d", 3'b010);
        expect_rsp(REQ_D, 19'h0ABCD, 1'b0);
      end
      tick();
    end
    clear_reqs();
    tick();
  endtask

  task automatic test_tlb_we();
    bus.d_req  = 1'b1;
    bus.d_vpn2 = 19'h00400;
    bus.d_odd  = 1'b1;
    bus.tlb_we = 1'b1;
    #1;
    chk_rdy("we_block1", 3'b000);
    tick();
    #1;
    chk_rdy("we_block2", 3'b000);
    tick();
    bus.tlb_we = 1'b0;
    #1;
    chk_rdy("we_grant", 3'b010);
    expect_rsp(REQ_D, 19'h00400, 1'b1);
    tick();
    bus.d_req = 1'b0;
    #1;
    chk_rv("we_rsp", 3'b010);
    tick();
  endtask

  task automatic test_flush();
    bus.d_req  = 1'b1;
    bus.d_vpn2 = 19'h05555;
    bus.flush  = 1'b1;
    #1;
    chk_rdy("flush_grant_d", 3'b010);
    tick();
    clear_reqs();
    #1;
    chk_rv("flush_drop_d", 3'b000);
    tick();
    bus.p_req  = 1'b1;
    bus.p_vpn2 = 19'h06666;
    #1;
    chk_rdy("flush_grant_p", 3'b100);
    expect_rsp(REQ_P, 19'h06666, 1'b0);
    tick();
    bus.p_req = 1'b0;
    bus.flush = 1'b1;
    #1;
    chk_rv("flush_keep_p", 3'b100);
    tick();
    bus.flush  = 1'b0;
    bus.i_req  = 1'b1;
    bus.i_vpn2 = 19'h07777;
    #1;
    chk_rdy("flush_grant_i", 3'b001);
    tick();
    bus.i_req = 1'b0;
    bus.flush = 1'b1;
    #1;
    chk_rv("flush_kill_i", 3'b000);
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [18:0] v;
    logic        o;
    for (int k = 0; k < 6; k++) begin
      clear_reqs();
      v = 19'($urandom);
      o = 1'($urandom);
      case (k % 3)
        0: begin
          bus.i_req = 1'b1; bus.i_vpn2 = v; bus.i_odd = o;
        end
        1: begin
          bus.d_req = 1'b1; bus.d_vpn2 = v; bus.d_odd = o;
        end
        default: begin
          bus.p_req = 1'b1; bus.p_vpn2 = v; bus.p_odd = o;
        end
      endcase
      #1;
      chk_rdy("b2b", 3'b001 << (k % 3));
      expect_rsp(2'(k % 3), v, (k % 3 == 2) ? 1'b0 : o);
      tick();
    end
    clear_reqs();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    bus.d_req  = 1'b1;
    bus.d_vpn2 = 19'h0A0A0;
    bus.d_odd  = 1'b0;
    bus.i_req  = 1'b1;
    bus.i_vpn2 = 19'h0B0B0;
    bus.i_odd  = 1'b0;
    #1;
    chk_rdy("rmid_d1", 3'b010);
    expect_rsp(REQ_D, 19'h0A0A0, 1'b0);
    tick();
    #1;
    chk_rdy("rmid_d2", 3'b010);
    tick();
    reset = 1'b1;
    #1;
    chk_rdy("rmid_in_reset", 3'b000);
    chk_rv("rmid_in_reset", 3'b000);
    tick();
    reset = 1'b0;
    #1;
    chk_rv("rmid_after", 3'b000);
    checks++;
    if ({bus.r_found, bus.r_index, bus.r_pfn, bus.r_c,
         bus.r_d, bus.r_v} !== 30'd0) begin
      errors++;
      $display("FAIL rmid_rbus got pfn=%h found=%b want 0",
               bus.r_pfn, bus.r_found);
    end
    // Counter cleared by reset: d must win three more times first.
    for (int k = 0; k < 4; k++) begin
      if (k > 0) #1;
      if (k == 3) begin
        chk_rdy("rmid_i", 3'b001);
        expect_rsp(REQ_I, 19'h0B0B0, 1'b0);
      end else begin
        chk_rdy("rmid_d", 3'b010);
        expect_rsp(REQ_D, 19'h0A0A0, 1'b0);
      end
      tick();
    end
    clear_reqs();
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    clear_reqs();
    bus.i_vpn2 = '0;
    bus.d_vpn2 = '0;
    bus.p_vpn2 = '0;
    bus.i_odd  = 1'b0;
    bus.d_odd  = 1'b0;
    bus.p_odd  = 1'b0;
    bus.asid   = 8'h00;
    #1;
    test_reset();
    test_single();
    test_priority();
    test_starve();
    test_tlb_we();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
